// File: rtl/raw10_pkg.sv
// Shared types and constants for the RGB to RAW10 Bayer re-sampler.
package raw10_pkg;

    localparam int RAW_W = 10;
    localparam int PIX_W = 12;

    localparam int BAYER_RGGB = 0;
    localparam int BAYER_GRBG = 1;
    localparam int BAYER_GBRG = 2;
    localparam int BAYER_BGGR = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } raw10_state_t;

    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/raw10_round.sv
// 12-bit to 10-bit reduction: round-half-up with saturation, or plain truncation.
module raw10_round
    import raw10_pkg::*;
#(
    parameter int ROUND_EN = 1
) (
    input  logic [PIX_W-1:0] pix_i,
    output logic [RAW_W-1:0] raw_o
);

    logic [RAW_W:0] sum;
    logic           unused_lsb;

    assign unused_lsb = pix_i[0];

    always_comb begin
        sum = {1'b0, pix_i[PIX_W-1:PIX_W-RAW_W]} + {{RAW_W{1'b0}}, pix_i[PIX_W-RAW_W-1]};
        if (ROUND_EN != 0) begin
            raw_o = sum[RAW_W] ? '1 : sum[RAW_W-1:0];
        end else begin
            raw_o = pix_i[PIX_W-1:PIX_W-RAW_W];
        end
    end

endmodule

// File: rtl/rgb_to_raw10.sv
// Converts parallel RGB video into a RAW10 Bayer sensor stream (fv/lv/data),
// with frame gating, line counting and sticky protocol-error detection.
module rgb_to_raw10
    import raw10_pkg::*;
#(
    parameter int BAYER_ORDER = BAYER_RGGB,
    parameter int ROUND_EN    = 1
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             vsync_i,
    input  logic             hsync_i,
    input  logic             de_i,
    input  logic [PIX_W-1:0] red_i,
    input  logic [PIX_W-1:0] green_i,
    input  logic [PIX_W-1:0] blue_i,
    output logic             fv_o,
    output logic             lv_o,
    output logic [RAW_W-1:0] data_o,
    output logic [PIX_W-1:0] line_cnt_o,
    output logic             frame_err_o
);

    localparam logic [1:0] BAYER_PH = BAYER_ORDER[1:0];

    logic [1:0]       rst_sync;
    logic             rst_n_int;

    logic             vsync_q, vsync_qq;
    logic             de_q, de_qq;
    logic             hsync_unused_q;
    logic [PIX_W-1:0] red_q, green_q, blue_q;

    raw10_state_t     state_q, state_d;
    logic             enter, pix_ok, abort;

    logic             vsync_rise, de_rise, de_fall, line_end;
    logic             pix_par_q, line_par_q, pix_cur, line_cur;
    logic [1:0]       sel;
    logic [PIX_W-1:0] ch;
    logic [RAW_W-1:0] raw;
    logic [PIX_W-1:0] len_q, len_cur, first_len_q;
    logic             first_vld_q, len_bad;

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // vsync history resets high so a level already high at release is not an edge.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            vsync_q        <= 1'b1;
            vsync_qq       <= 1'b1;
            de_q           <= 1'b0;
            de_qq          <= 1'b0;
            hsync_unused_q <= 1'b0;
            red_q          <= '0;
            green_q        <= '0;
            blue_q         <= '0;
        end else begin
            vsync_q        <= vsync_i;
            vsync_qq       <= vsync_q;
            de_q           <= de_i;
            de_qq          <= de_q;
            hsync_unused_q <= hsync_i;
            red_q          <= red_i;
            green_q        <= green_i;
            blue_q         <= blue_i;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_qq;
    assign de_rise    = de_q & ~de_qq;
    assign de_fall    = ~de_q & de_qq;

    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ARMED waits for a line start so a partial line after an abort is skipped.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        pix_ok  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vsync_rise) begin
                    abort = de_q;
                end else if (de_rise) begin
                    state_d = ST_ACTIVE;
                    enter   = 1'b1;
                    pix_ok  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    state_d = ST_ARMED;
                    abort   = de_q;
                end else begin
                    pix_ok = de_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_cur  = de_rise ? 1'b0 : pix_par_q;
        line_cur = enter ? 1'b0 : line_par_q;
        sel      = {line_cur, pix_cur} ^ BAYER_PH;
        case (sel)
            2'b00:   ch = red_q;
            2'b11:   ch = blue_q;
            default: ch = green_q;
        endcase
        len_cur  = de_rise ? PIX_W'(1) : sat_inc(len_q);
        line_end = de_fall && (state_q == ST_ACTIVE);
        len_bad  = line_end && first_vld_q && (len_q != first_len_q);
    end

    raw10_round #(
        .ROUND_EN(ROUND_EN)
    ) u_round (
        .pix_i(ch),
        .raw_o(raw)
    );

    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pix_par_q   <= 1'b0;
            line_par_q  <= 1'b0;
            len_q       <= '0;
            first_len_q <= '0;
            first_vld_q <= 1'b0;
            fv_o        <= 1'b0;
            lv_o        <= 1'b0;
            data_o      <= '0;
            line_cnt_o  <= '0;
            frame_err_o <= 1'b0;
        end else begin
            if (de_q) begin
                pix_par_q <= ~pix_cur;
                len_q     <= len_cur;
            end
            if (enter) begin
                line_par_q  <= 1'b0;
                line_cnt_o  <= '0;
                first_vld_q <= 1'b0;
                fv_o        <= 1'b1;
            end else begin
                if (line_end) begin
                    line_par_q <= ~line_par_q;
                    line_cnt_o <= sat_inc(line_cnt_o);
                    if (!first_vld_q) begin
                        first_vld_q <= 1'b1;
                        first_len_q <= len_q;
                    end
                end
                if ((state_q == ST_ACTIVE) && vsync_rise) begin
                    fv_o <= 1'b0;
                end
            end
            if (abort || len_bad) begin
                frame_err_o <= 1'b1;
            end
            lv_o   <= pix_ok;
            data_o <= pix_ok ? raw : '0;
        end
    end

endmodule

// File: tb/tb_rgb_to_raw10.sv
// Directed bench for rgb_to_raw10: RGGB/BGGR framing, rounding modes, error and reset cases.
module tb_rgb_to_raw10;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b1;
    logic        vsync_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0;
    logic [11:0] red_i = '0, green_i = '0, blue_i = '0;

    logic        fv_o, lv_o, frame_err_o;
    logic [9:0]  data_o;
    logic [11:0] line_cnt_o;
    logic        fv_tr, lv_tr, err_tr;
    logic [9:0]  data_tr;
    logic [11:0] lc_tr;
    logic        fv_bg, lv_bg, err_bg;
    logic [9:0]  data_bg;
    logic [11:0] lc_bg;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    logic lv_seen, fv_seen;
    logic [9:0] q_main[$], q_tr[$], q_bg[$], exp_q[$];

    always #5 clk_i = ~clk_i;

    rgb_to_raw10 dut (
        .clk_i(clk_i), .reset_n(reset_n), .vsync_i(vsync_i), .hsync_i(hsync_i), .de_i(de_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .fv_o(fv_o), .lv_o(lv_o), .data_o(data_o), .line_cnt_o(line_cnt_o), .frame_err_o(frame_err_o)
    );

    rgb_to_raw10 #(.BAYER_ORDER(0), .ROUND_EN(0)) dut_tr (
        .clk_i(clk_i), .reset_n(reset_n), .vsync_i(vsync_i), .hsync_i(hsync_i), .de_i(de_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .fv_o(fv_tr), .lv_o(lv_tr), .data_o(data_tr), .line_cnt_o(lc_tr), .frame_err_o(err_tr)
    );

    rgb_to_raw10 #(.BAYER_ORDER(3), .ROUND_EN(1)) dut_bg (
        .clk_i(clk_i), .reset_n(reset_n), .vsync_i(vsync_i), .hsync_i(hsync_i), .de_i(de_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .fv_o(fv_bg), .lv_o(lv_bg), .data_o(data_bg), .line_cnt_o(lc_bg), .frame_err_o(err_bg)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [9:0] got[$], input logic [9:0] exp[$]);
        check_val({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check_val($sformatf("%s[%0d]", tag, i),
                      (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (lv_o)  q_main.push_back(data_o);
        if (lv_tr) q_tr.push_back(data_tr);
        if (lv_bg) q_bg.push_back(data_bg);
        lv_seen = lv_seen | lv_o;
        fv_seen = fv_seen | fv_o;
        if ((lv_o && !fv_o) || (!lv_o && data_o != 10'd0)) viol++;
    endtask

    task automatic idle(input int n);
        de_i = 1'b0;
        vsync_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vsync_pulse();
        vsync_i = 1'b1;
        tick();
        tick();
        vsync_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic pix(input logic [11:0] v);
        de_i = 1'b1;
        red_i = v;
        green_i = v;
        blue_i = v;
        tick();
    endtask

    task automatic line(input int n, input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        hsync_i = 1'b1;
        tick();
        hsync_i = 1'b0;
        red_i = r;
        green_i = g;
        blue_i = b;
        de_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        idle(4);
    endtask

    task automatic clear_q();
        q_main.delete();
        q_tr.delete();
        q_bg.delete();
    endtask

    initial begin
        lv_seen = 1'b0;
        fv_seen = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_fv", 32'(fv_o), 0);
        check_val("rst_lv", 32'(lv_o), 0);
        check_val("rst_data", 32'(data_o), 0);
        check_val("rst_line_cnt", 32'(line_cnt_o), 0);
        check_val("rst_err", 32'(frame_err_o), 0);
        tick();
        tick();
        reset_n = 1'b1;
        idle(4);

        // de activity before any vsync must produce nothing
        lv_seen = 1'b0;
        fv_seen = 1'b0;
        line(4, 12'h400, 12'h800, 12'hC00);
        line(4, 12'h400, 12'h800, 12'hC00);
        check_val("pre_vsync_lv", 32'(lv_seen), 0);
        check_val("pre_vsync_fv", 32'(fv_seen), 0);

        // RGGB 4x2 frame with two-cycle latency check on the first pixel
        vsync_pulse();
        clear_q();
        de_i = 1'b1;
        red_i = 12'h400;
        green_i = 12'h800;
        blue_i = 12'hC00;
        tick();
        check_val("lat_lv_c1", 32'(lv_o), 0);
        check_val("lat_fv_c1", 32'(fv_o), 0);
        tick();
        check_val("lat_lv_c2", 32'(lv_o), 1);
        check_val("lat_fv_c2", 32'(fv_o), 1);
        check_val("lat_data_c2", 32'(data_o), 32'h100);
        tick();
        tick();
        idle(4);
        line(4, 12'h400, 12'h800, 12'hC00);
        exp_q = '{10'h100, 10'h200, 10'h100, 10'h200, 10'h200, 10'h300, 10'h200, 10'h300};
        check_q("rggb", q_main, exp_q);
        exp_q = '{10'h300, 10'h200, 10'h300, 10'h200, 10'h200, 10'h100, 10'h200, 10'h100};
        check_q("bggr", q_bg, exp_q);
        check_val("frame_fv_held", 32'(fv_o), 1);
        check_val("frame_line_cnt", 32'(line_cnt_o), 2);
        check_val("frame_err_clean", 32'(frame_err_o), 0);
        vsync_i = 1'b1;
        tick();
        check_val("fv_fall_c1", 32'(fv_o), 1);
        tick();
        check_val("fv_fall_c2", 32'(fv_o), 0);
        vsync_i = 1'b0;
        tick();
        tick();

        // rounding versus truncation
        clear_q();
        pix(12'hFFF);
        pix(12'h006);
        pix(12'h002);
        idle(4);
        exp_q = '{10'h3FF, 10'h002, 10'h001};
        check_q("round", q_main, exp_q);
        exp_q = '{10'h3FF, 10'h001, 10'h000};
        check_q("trunc", q_tr, exp_q);
        check_val("round_err", 32'(frame_err_o), 0);

        // vsync rising edge in the middle of a line
        vsync_pulse();
        pix(12'h400);
        pix(12'h400);
        vsync_i = 1'b1;
        tick();
        check_val("abort_lv_c1", 32'(lv_o), 1);
        tick();
        check_val("abort_lv_c2", 32'(lv_o), 0);
        check_val("abort_fv_c2", 32'(fv_o), 0);
        check_val("abort_err", 32'(frame_err_o), 1);
        tick();
        check_val("abort_lv_c3", 32'(lv_o), 0);
        idle(4);
        clear_q();
        line(4, 12'h400, 12'h800, 12'hC00);
        line(4, 12'h400, 12'h800, 12'hC00);
        exp_q = '{10'h100, 10'h200, 10'h100, 10'h200, 10'h200, 10'h300, 10'h200, 10'h300};
        check_q("after_abort", q_main, exp_q);
        check_val("after_abort_line_cnt", 32'(line_cnt_o), 2);
        check_val("err_sticky", 32'(frame_err_o), 1);

        // reset pulse in mid-line
        pix(12'h800);
        pix(12'h800);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_fv", 32'(fv_o), 0);
        check_val("mid_rst_lv", 32'(lv_o), 0);
        check_val("mid_rst_data", 32'(data_o), 0);
        check_val("mid_rst_line_cnt", 32'(line_cnt_o), 0);
        check_val("mid_rst_err", 32'(frame_err_o), 0);
        lv_seen = 1'b0;
        fv_seen = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        pix(12'h800);
        pix(12'h800);
        pix(12'h800);
        idle(4);
        line(4, 12'h400, 12'h800, 12'hC00);
        check_val("post_rst_lv", 32'(lv_seen), 0);
        check_val("post_rst_fv", 32'(fv_seen), 0);

        // line length change within a frame
        vsync_pulse();
        line(4, 12'h400, 12'h800, 12'hC00);
        check_val("post_rst_lv_resumes", 32'(lv_seen), 1);
        check_val("len_err_first", 32'(frame_err_o), 0);
        line(6, 12'h400, 12'h800, 12'hC00);
        check_val("len_err", 32'(frame_err_o), 1);
        check_val("len_line_cnt", 32'(line_cnt_o), 2);

        check_val("lv_fv_data_viol", 32'(viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
